// File: rtl/eth_pkg.sv
// Shared Ethernet transmit definitions: framer states, line constants and
// the bit-order helper used between the framer and the CRC engine.
package eth_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_SFD  = 3'd2,
      S_DATA = 3'd3,
      S_PAD  = 3'd4,
      S_FCS  = 3'd5,
      S_IFG  = 3'd6
   } state_t;

   localparam logic [7:0] ETH_PREAMBLE = 8'h55;
   localparam logic [7:0] ETH_SFD      = 8'hD5;
   localparam int         ETH_MIN_LEN  = 60;
   localparam int         ETH_IFG      = 12;
   localparam int         ETH_PRE_LEN  = 7;

   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload-side handshake and GMII-side line signals of the transmit framer.
interface eth_tx_framer_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_er;
   logic       busy;

   modport master (
      output in_data, in_valid, in_last,
      input  in_ready, tx_data, tx_en, tx_er, busy
   );

   modport slave (
      input  in_data, in_valid, in_last,
      output in_ready, tx_data, tx_en, tx_er, busy
   );

endinterface

// File: rtl/crc.sv
// Byte-wide CRC-32 (poly 0x04C11DB7), MSB-first register, Data[7] shifted in
// first; preset to all ones on Reset.
module crc (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Enable,
   input  logic [7:0]  Data,
   output logic [31:0] Crc
);

   function automatic logic [31:0] crc32_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0000_0000);
      end
      return r;
   endfunction

   // CRC register, advanced one byte per enabled cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Crc <= 32'hFFFF_FFFF;
      end else if (Enable) begin
         Crc <= crc32_next(Crc, Data);
      end
   end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, zero pad, FCS and
// inter-frame gap onto a registered GMII-style byte stream.
module eth_tx_framer
   import eth_pkg::*;
#(
   parameter int MIN_LEN = ETH_MIN_LEN,
   parameter int PRE_LEN = ETH_PRE_LEN,
   parameter int IFG_LEN = ETH_IFG
) (
   input logic            Clk,
   input logic            Reset,
   eth_tx_framer_if.slave bus
);

   state_t      state_r, state_s;
   logic [15:0] byte_cnt_r, byte_cnt_s;
   logic [15:0] step_cnt_r, step_cnt_s;
   logic [15:0] byte_inc_s;
   logic [7:0]  tx_data_r, tx_data_s;
   logic        tx_en_r, tx_en_s;
   logic        tx_er_r, tx_er_s;
   logic        crc_init_r;
   logic        crc_en_s;
   logic [7:0]  crc_data_s;
   logic [31:0] crc_val_s;
   logic [4:0]  fcs_base_s;
   logic        cnt_short_s;

   assign byte_inc_s  = (byte_cnt_r == 16'hFFFF) ? byte_cnt_r : byte_cnt_r + 16'd1;
   assign cnt_short_s = ({1'b0, byte_cnt_r} + 17'd1) < 17'(MIN_LEN);
   assign fcs_base_s  = 5'd31 - {step_cnt_r[1:0], 3'b000};

   assign bus.in_ready = (state_r == S_DATA);
   assign bus.busy     = (state_r != S_IDLE);
   assign bus.tx_data  = tx_data_r;
   assign bus.tx_en    = tx_en_r;
   assign bus.tx_er    = tx_er_r;

   // Next-state, counter and line-byte decisions
   always_comb begin
      state_s    = state_r;
      byte_cnt_s = byte_cnt_r;
      step_cnt_s = step_cnt_r;
      tx_data_s  = 8'h00;
      tx_en_s    = 1'b0;
      tx_er_s    = 1'b0;
      crc_en_s   = 1'b0;
      crc_data_s = 8'h00;
      case (state_r)
         S_IDLE: begin
            byte_cnt_s = 16'd0;
            step_cnt_s = 16'd0;
            if (bus.in_valid) begin
               state_s = S_PRE;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PRE: begin
            tx_data_s = ETH_PREAMBLE;
            tx_en_s   = 1'b1;
            if (step_cnt_r == 16'(PRE_LEN - 1)) begin
               step_cnt_s = 16'd0;
               state_s    = S_SFD;
            end else begin
               step_cnt_s = step_cnt_r + 16'd1;
            end
         end
         S_SFD: begin
            tx_data_s = ETH_SFD;
            tx_en_s   = 1'b1;
            state_s   = S_DATA;
         end
         S_DATA: begin
            tx_en_s = 1'b1;
            if (bus.in_valid) begin
               tx_data_s  = bus.in_data;
               crc_en_s   = 1'b1;
               crc_data_s = bit_rev8(bus.in_data);
               byte_cnt_s = byte_inc_s;
               if (!bus.in_last) begin
                  state_s = S_DATA;
               end else if (cnt_short_s) begin
                  state_s = S_PAD;
               end else begin
                  step_cnt_s = 16'd0;
                  state_s    = S_FCS;
               end
            end else begin
               // Underrun: mark the line and abandon the frame without FCS
               tx_er_s    = 1'b1;
               step_cnt_s = 16'd0;
               state_s    = S_IFG;
            end
         end
         S_PAD: begin
            tx_en_s    = 1'b1;
            crc_en_s   = 1'b1;
            byte_cnt_s = byte_inc_s;
            if (cnt_short_s) begin
               state_s = S_PAD;
            end else begin
               step_cnt_s = 16'd0;
               state_s    = S_FCS;
            end
         end
         S_FCS: begin
            tx_data_s = ~bit_rev8(crc_val_s[fcs_base_s -: 8]);
            tx_en_s   = 1'b1;
            if (step_cnt_r[1:0] == 2'd3) begin
               step_cnt_s = 16'd0;
               state_s    = S_IFG;
            end else begin
               step_cnt_s = step_cnt_r + 16'd1;
            end
         end
         S_IFG: begin
            // The IDLE cycle that follows supplies the last gap cycle
            if (step_cnt_r >= 16'(IFG_LEN - 2)) begin
               step_cnt_s = 16'd0;
               state_s    = S_IDLE;
            end else begin
               step_cnt_s = step_cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, counters and registered line outputs
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= S_IDLE;
         byte_cnt_r <= 16'd0;
         step_cnt_r <= 16'd0;
         tx_data_r  <= 8'h00;
         tx_en_r    <= 1'b0;
         tx_er_r    <= 1'b0;
         crc_init_r <= 1'b1;
      end else begin
         state_r    <= state_s;
         byte_cnt_r <= byte_cnt_s;
         step_cnt_r <= step_cnt_s;
         tx_data_r  <= tx_data_s;
         tx_en_r    <= tx_en_s;
         tx_er_r    <= tx_er_s;
         crc_init_r <= (state_s == S_IDLE) || (state_s == S_PRE) || (state_s == S_IFG);
      end
   end

   crc u_crc (
      .Clk    (Clk),
      .Reset  (Reset | crc_init_r),
      .Enable (crc_en_s),
      .Data   (crc_data_s),
      .Crc    (crc_val_s)
   );

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected line bytes are queued when a
// frame is driven and compared as tx_en bytes appear.
module tb_eth_tx_framer;
   import eth_pkg::*;

   typedef logic [7:0] bq_t[$];

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   eth_tx_framer_if bus();
   eth_tx_framer_if bus0();

   eth_tx_framer #(.MIN_LEN(60), .PRE_LEN(7), .IFG_LEN(12)) u_dut (
      .Clk(Clk), .Reset(Reset), .bus(bus));
   eth_tx_framer #(.MIN_LEN(0), .PRE_LEN(7), .IFG_LEN(12)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .bus(bus0));

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [31:0] crc_ref(input bq_t d);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (d[i]) begin
         c = c ^ {24'h0, d[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   logic [8:0] exp_q[$];
   int         len_q[$];
   logic [7:0] rx0[$];

   task automatic push_frame(input bq_t p, input int under_at);
      bq_t         padded;
      logic [31:0] c;
      repeat (7) exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'hD5});
      if (under_at >= 0) begin
         for (int i = 0; i < under_at; i++) exp_q.push_back({1'b0, p[i]});
         exp_q.push_back({1'b1, 8'h00});
         len_q.push_back(8 + under_at + 1);
      end else begin
         padded = p;
         while (padded.size() < 60) padded.push_back(8'h00);
         foreach (padded[i]) exp_q.push_back({1'b0, padded[i]});
         c = crc_ref(padded);
         exp_q.push_back({1'b0, c[7:0]});
         exp_q.push_back({1'b0, c[15:8]});
         exp_q.push_back({1'b0, c[23:16]});
         exp_q.push_back({1'b0, c[31:24]});
         len_q.push_back(8 + padded.size() + 4);
      end
   endtask

   // Line monitor: scoreboard pop, frame length and inter-frame gap
   int         cyc = 0;
   logic       prev_en = 1'b0;
   int         run = 0, gap = 0, last_gap = -1, start_cyc = 0, exp_len;
   logic [8:0] e;
   always @(posedge Clk) cyc <= cyc + 1;
   always @(negedge Clk) begin
      if (bus.tx_en) begin
         if (!prev_en) begin
            last_gap  = gap;
            start_cyc = cyc;
         end
         run++;
         gap = 0;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_tx", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("tx_byte", {23'h0, bus.tx_er, bus.tx_data}, {23'h0, e});
         end
      end else begin
         if (prev_en && len_q.size() > 0) begin
            exp_len = len_q.pop_front();
            check_eq("frame_len", 32'(run), 32'(exp_len));
         end
         run = 0;
         gap++;
      end
      prev_en = bus.tx_en;
      if (bus0.tx_en) rx0.push_back(bus0.tx_data);
   end

   task automatic drive_byte(input logic [7:0] d, input logic last);
      int n = 0;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 100) check_eq("ready_timeout", 32'(n), 32'd0);
      @(negedge Clk);
   endtask

   task automatic send(input bq_t p, input int under_at, input bit hold);
      for (int i = 0; i < p.size(); i++) begin
         if (under_at >= 0 && i == under_at) begin
            bus.in_valid = 1'b0;
            @(negedge Clk);
            return;
         end
         drive_byte(p[i], (i == p.size() - 1) && (under_at < 0));
      end
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 1000) begin
         @(negedge Clk);
         n++;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   bq_t p9, p60, pa, pb, p1;
   int  c0, n;

   initial begin
      bus.in_data = 8'h00;  bus.in_valid = 1'b0;  bus.in_last = 1'b0;
      bus0.in_data = 8'h00; bus0.in_valid = 1'b0; bus0.in_last = 1'b0;
      p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      for (int i = 0; i < 60; i++) p60.push_back(8'(i));
      for (int i = 0; i < 64; i++) pa.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 64; i++) pb.push_back(8'($urandom_range(0, 255)));

      repeat (3) @(negedge Clk);
      check_eq("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      check_eq("rst_tx_en", {31'h0, bus.tx_en}, 32'h0);
      check_eq("rst_tx_er", {31'h0, bus.tx_er}, 32'h0);
      check_eq("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
      Reset = 1'b0;
      @(negedge Clk);

      // CRC mapping with no padding: FCS of "123456789"
      for (int i = 0; i < 9; i++) begin
         bus0.in_data = p9[i]; bus0.in_last = (i == 8); bus0.in_valid = 1'b1;
         n = 0;
         while (!bus0.in_ready && n < 100) begin @(negedge Clk); n++; end
         @(negedge Clk);
      end
      bus0.in_valid = 1'b0;
      repeat (40) @(negedge Clk);
      check_eq("min0_len", 32'(rx0.size()), 32'd21);
      if (rx0.size() == 21)
         check_eq("min0_fcs", {rx0[20], rx0[19], rx0[18], rx0[17]}, 32'hCBF4_3926);

      // Check vector with padding, plus start latency
      push_frame(p9, -1);
      c0 = cyc;
      send(p9, -1, 1'b0);
      wait_idle();
      check_eq("start_latency", 32'(start_cyc - c0), 32'd2);

      // Underrun after 5 bytes, then a minimum-length frame queued behind it
      push_frame(p60, 5);
      push_frame(p60, -1);
      send(p60, 5, 1'b0);
      send(p60, -1, 1'b0);
      wait_idle();
      check_eq("underrun_gap", 32'(last_gap), 32'd12);

      // Back-to-back 64-byte frames with in_valid held high
      push_frame(pa, -1);
      push_frame(pb, -1);
      send(pa, -1, 1'b1);
      send(pb, -1, 1'b0);
      wait_idle();
      check_eq("b2b_gap", 32'(last_gap), 32'd12);

      // Reset during PAD, then a clean 1-byte frame
      p1 = '{8'hA7};
      push_frame(p1, -1);
      send(p1, -1, 1'b0);
      repeat (10) @(negedge Clk);
      check_eq("pad_busy", {31'h0, bus.busy}, 32'h1);
      #2 Reset = 1'b1;
      #1;
      check_eq("midrst_tx_en", {31'h0, bus.tx_en}, 32'h0);
      check_eq("midrst_busy", {31'h0, bus.busy}, 32'h0);
      check_eq("midrst_tx_data", {24'h0, bus.tx_data}, 32'h0);
      exp_q.delete();
      len_q.delete();
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      p1 = '{8'h3C};
      push_frame(p1, -1);
      send(p1, -1, 1'b0);
      wait_idle();
      check_eq("len_q_empty", 32'(len_q.size()), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
